// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family (pipelined alu_pipe and the
// unpipelined datapath that reuses alu_core).
//   - 3-bit opcode encodings
//   - bit positions of Z/N/C/V inside a packed 4-bit flag word {z,n,c,v}
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_NEG   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_PASSA = 3'b111;
    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: opcode/a/b -> result and Z/N/C/V flags.
// Ports:
//   opcode  : operation select (alu_pkg::OP_*)
//   a, b    : WIDTH-bit operands
//   result  : WIDTH-bit result
//   z, n    : result is zero / result MSB
//   c       : carry out (ADD), no-borrow (SUB), b==0 (NEG), else 0
//   v       : signed overflow for ADD/SUB/NEG, else 0
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    // One extra bit so the carry out of the adder is captured directly.
    logic [WIDTH:0] sum_ext;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through this block can leave a value unassigned (no latch).
        sum_ext = '0;
        result  = '0;
        c       = 1'b0;
        v       = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                result  = sum_ext[WIDTH-1:0];
                c       = sum_ext[WIDTH];
                v       = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // b - a as b + ~a + 1; the carry out means "no borrow" (b >= a).
                sum_ext = {1'b0, b} + {1'b0, ~a} + ONE_EXT;
                result  = sum_ext[WIDTH-1:0];
                c       = sum_ext[WIDTH];
                v       = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
            end
            OP_NEG: begin
                sum_ext = {1'b0, ~b} + ONE_EXT;
                result  = sum_ext[WIDTH-1:0];
                c       = (b == '0);
                v       = (b == MOST_NEG);
            end
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
        endcase
    end

    assign z = (result == '0);
    assign n = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
//   S1 registers the accepted opcode/operands; S2 registers the alu_core
//   result and flags. One op per cycle, at most two ops in flight.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready depends on out_ready
//                         and pipeline state only, never on in_valid)
//   opcode, a, b        : operation and WIDTH-bit operands
//   out_valid/out_ready : output handshake
//   result, z, n, c, v  : S2 result and flags, held while stalled
//   flags_q             : {z,n,c,v} of the last consumed result
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic [3:0]       flags_q
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [3:0]       flags_d;
    logic             s1_en, s2_en;

    logic [WIDTH-1:0] core_result;
    logic             core_z, core_n, core_c, core_v;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode (s1_op_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (core_result),
        .z      (core_z),
        .n      (core_n),
        .c      (core_c),
        .v      (core_v)
    );

    always_comb begin
        // NOTE: combinational logic uses blocking assignments so later
        // statements see the values computed earlier in the same block.
        // A stage may advance when it is empty or its contents leave.
        s2_en    = !s2_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_ready = s1_en;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        s2_flags_d = s2_flags_q;
        flags_d    = flags_q;

        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d = opcode;
                s1_a_d  = a;
                s1_b_d  = b;
            end
        end

        // A bubble only clears s2_valid; result/flags keep their last value.
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d   = core_result;
                s2_flags_d = {core_z, core_n, core_c, core_v};
            end
        end

        if (s2_valid_q && out_ready) begin
            flags_d = s2_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset along with the valid bits so
        // the visible outputs read as zero out of reset, not stale data.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            s2_flags_q <= '0;
            flags_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from the pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            s2_flags_q <= s2_flags_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign z         = s2_flags_q[FLG_Z];
    assign n         = s2_flags_q[FLG_N];
    assign c         = s2_flags_q[FLG_C];
    assign v         = s2_flags_q[FLG_V];

endmodule
